mute_sequencer: RTL and testbench

MUTE_SEQUENCER -- requirements
Module: mute_sequencer

---
 rtl/mute_sequencer.sv | 179 +++++++++++++++++
 tb/tb_mute_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mute_sequencer.sv
// mute_sequencer: sequences a glitch-free mute/unmute handshake with an
// external clock/data exchanger. Requests force a mute; unmute happens only
// after all requests drop and a programmable hold time (in fs ticks) expires.
//
// Ports:
//   mck_i       master clock, all logic on posedge
//   nrst_i      asynchronous active-low reset
//   req_i       level mute requests (asynchronous, synchronized here)
//   fs_tick_i   one-cycle pulse per sample period (synchronous)
//   hold_len_i  unmute hold length in fs ticks, captured on HOLD entry
//   nclkmute_i  exchanger clock-select flag, 0 mute / 1 play (asynchronous)
//   ndatmute_i  exchanger data-select flag, 0 mute / 1 play (asynchronous)
//   mute_o      mute command to the exchanger
//   state_o     current state encoding
//   src_o       requests seen since the last entry to MUTING
//   tmo_o       sticky acknowledge-timeout flag
module mute_sequencer #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned HOLD_W  = 12,
    parameter int unsigned TMO_W   = 16
) (
    input  logic               mck_i,
    input  logic               nrst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               fs_tick_i,
    input  logic [HOLD_W-1:0]  hold_len_i,
    input  logic               nclkmute_i,
    input  logic               ndatmute_i,
    output logic               mute_o,
    output logic [2:0]         state_o,
    output logic [NUM_REQ-1:0] src_o,
    output logic               tmo_o
);

    typedef enum logic [2:0] {
        ST_PLAY     = 3'd0,
        ST_MUTING   = 3'd1,
        ST_MUTED    = 3'd2,
        ST_HOLD     = 3'd3,
        ST_UNMUTING = 3'd4
    } state_e;

    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    // Leaving on the cycle the counter steps onto TMO_MAX makes the timeout
    // coincide with saturation.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);

    state_e              state_q;
    state_e              state_d;
    logic [NUM_REQ-1:0]  req_s1;
    logic [NUM_REQ-1:0]  req_s2;
    logic [1:0]          ack_s1;
    logic [1:0]          ack_s2;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic                any_req;
    logic                acked_mute;
    logic                acked_play;
    logic                tmo_hit;
    logic                tmo_set;
    logic                hold_dec;
    logic                enter_muting;
    logic                enter_timed;
    logic                enter_hold;
    logic                in_timed;

    // Two-flop synchronizers for every asynchronous input.
    always_ff @(posedge mck_i or negedge nrst_i) begin
        if (!nrst_i) begin
            req_s1 <= '0;
            req_s2 <= '0;
            ack_s1 <= '0;
            ack_s2 <= '0;
        end else begin
            req_s1 <= req_i;
            req_s2 <= req_s1;
            ack_s1 <= {nclkmute_i, ndatmute_i};
            ack_s2 <= ack_s1;
        end
    end

    assign any_req    = |req_s2;
    assign acked_mute = (ack_s2 == 2'b00);
    assign acked_play = (ack_s2 == 2'b11);
    assign in_timed   = (state_q == ST_MUTING) || (state_q == ST_UNMUTING);
    assign tmo_hit    = (tmo_cnt_q >= TMO_LAST);

    // Next-state decode; request abort outranks acknowledge and timeout.
    always_comb begin
        state_d  = state_q;
        tmo_set  = 1'b0;
        hold_dec = 1'b0;
        case (state_q)
            ST_PLAY: begin
                if (any_req) state_d = ST_MUTING;
            end
            ST_MUTING: begin
                if (acked_mute) begin
                    state_d = ST_MUTED;
                end else if (tmo_hit) begin
                    state_d = ST_MUTED;
                    tmo_set = 1'b1;
                end
            end
            ST_MUTED: begin
                if (!any_req) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (any_req) begin
                    state_d = ST_MUTED;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_UNMUTING;
                end else if (fs_tick_i) begin
                    hold_dec = 1'b1;
                end
            end
            ST_UNMUTING: begin
                if (any_req) begin
                    state_d = ST_MUTING;
                end else if (acked_play) begin
                    state_d = ST_PLAY;
                end else if (tmo_hit) begin
                    state_d = ST_PLAY;
                    tmo_set = 1'b1;
                end
            end
            default: state_d = ST_MUTING;
        endcase
    end

    assign enter_muting = (state_d == ST_MUTING) && (state_q != ST_MUTING);
    assign enter_hold   = (state_d == ST_HOLD) && (state_q != ST_HOLD);
    assign enter_timed  = ((state_d == ST_MUTING) || (state_d == ST_UNMUTING))
                          && (state_d != state_q);

    // State, counters and registered outputs; reset lands in MUTED so the
    // first unmute always goes through the hold sequence.
    always_ff @(posedge mck_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q    <= ST_MUTED;
            mute_o     <= 1'b1;
            src_o      <= '0;
            tmo_o      <= 1'b0;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mute_o  <= (state_d == ST_MUTING) || (state_d == ST_MUTED)
                       || (state_d == ST_HOLD);

            if (enter_hold) begin
                hold_cnt_q <= hold_len_i;
            end else if (hold_dec) begin
                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end

            if (enter_timed) begin
                tmo_cnt_q <= '0;
            end else if (in_timed && (tmo_cnt_q != TMO_MAX)) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end

            if (enter_muting) begin
                tmo_o <= 1'b0;
            end else if (tmo_set) begin
                tmo_o <= 1'b1;
            end

            if (enter_muting) begin
                src_o <= '0;
            end else if (state_q != ST_PLAY) begin
                src_o <= src_o | req_s2;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mute_sequencer.sv
// Testbench for mute_sequencer: directed scenarios plus a randomized run
// checked cycle by cycle against a behavioural reference model.
module tb_mute_sequencer;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned HOLD_W  = 12;
    localparam int unsigned TMO_W   = 4;
    localparam int TMO_LIMIT  = (1 << TMO_W) - 1;
    localparam int S_PLAY     = 0;
    localparam int S_MUTING   = 1;
    localparam int S_MUTED    = 2;
    localparam int S_HOLD     = 3;
    localparam int S_UNMUTING = 4;

    logic               mck_i      = 1'b0;
    logic               nrst_i     = 1'b0;
    logic [NUM_REQ-1:0] req_i      = '0;
    logic               fs_tick_i  = 1'b0;
    logic [HOLD_W-1:0]  hold_len_i = 12'd4;
    logic               nclkmute_i = 1'b0;
    logic               ndatmute_i = 1'b0;
    logic               mute_o;
    logic [2:0]         state_o;
    logic [NUM_REQ-1:0] src_o;
    logic               tmo_o;

    int checks = 0;
    int errors = 0;

    // Exchanger emulation: acks follow !mute_o through a delay line, or are forced.
    int ack_mode  = 0;
    bit ack_force = 1'b0;
    int ack_dly   = 10;
    bit dline [16];
    int tick_mode = 0;
    int tick_ctr  = 0;

    // Reference model state.
    int                 m_state = S_MUTED;
    int                 m_left  = 0;
    int                 m_dwell = 0;
    logic [NUM_REQ-1:0] m_src   = '0;
    bit                 m_tmo   = 1'b0;
    logic [NUM_REQ-1:0] m_r1    = '0;
    logic [NUM_REQ-1:0] m_r2    = '0;
    bit                 m_c1 = 1'b0, m_c2 = 1'b0, m_d1 = 1'b0, m_d2 = 1'b0;

    mute_sequencer #(
        .NUM_REQ (NUM_REQ),
        .HOLD_W  (HOLD_W),
        .TMO_W   (TMO_W)
    ) dut (
        .mck_i      (mck_i),
        .nrst_i     (nrst_i),
        .req_i      (req_i),
        .fs_tick_i  (fs_tick_i),
        .hold_len_i (hold_len_i),
        .nclkmute_i (nclkmute_i),
        .ndatmute_i (ndatmute_i),
        .mute_o     (mute_o),
        .state_o    (state_o),
        .src_o      (src_o),
        .tmo_o      (tmo_o)
    );

    always #5 mck_i = ~mck_i;

    task automatic model_reset();
        m_state = S_MUTED;
        m_left  = 0;
        m_dwell = 0;
        m_src   = '0;
        m_tmo   = 1'b0;
        m_r1 = '0; m_r2 = '0;
        m_c1 = 1'b0; m_c2 = 1'b0; m_d1 = 1'b0; m_d2 = 1'b0;
    endtask

    // One clock of the specified behaviour, using the inputs seen at this edge.
    task automatic model_step();
        int  nxt;
        bit  rq;
        rq  = (m_r2 != '0);
        nxt = m_state;
        if (m_state == S_MUTING || m_state == S_UNMUTING) m_dwell = m_dwell + 1;
        case (m_state)
            S_PLAY:     if (rq) nxt = S_MUTING;
            S_MUTING: begin
                if (!m_c2 && !m_d2) nxt = S_MUTED;
                else if (m_dwell >= TMO_LIMIT) begin nxt = S_MUTED; m_tmo = 1'b1; end
            end
            S_MUTED:    if (!rq) nxt = S_HOLD;
            S_HOLD: begin
                if (rq) nxt = S_MUTED;
                else if (m_left == 0) nxt = S_UNMUTING;
                else if (fs_tick_i) m_left = m_left - 1;
            end
            S_UNMUTING: begin
                if (rq) nxt = S_MUTING;
                else if (m_c2 && m_d2) nxt = S_PLAY;
                else if (m_dwell >= TMO_LIMIT) begin nxt = S_PLAY; m_tmo = 1'b1; end
            end
            default:    nxt = S_MUTING;
        endcase
        if (nxt == S_MUTING && m_state != S_MUTING) begin
            m_src = '0;
            m_tmo = 1'b0;
        end else if (m_state != S_PLAY) begin
            m_src = m_src | m_r2;
        end
        if (nxt != m_state) begin
            m_dwell = 0;
            if (nxt == S_HOLD) m_left = int'(hold_len_i);
        end
        m_state = nxt;
        m_r2 = m_r1; m_r1 = req_i;
        m_c2 = m_c1; m_c1 = nclkmute_i;
        m_d2 = m_d1; m_d1 = ndatmute_i;
    endtask

    // Advance one clock: model steps at posedge, new stimulus at negedge.
    task automatic cyc();
        @(posedge mck_i);
        if (!nrst_i) model_reset();
        else model_step();
        @(negedge mck_i);
        for (int i = 15; i > 0; i--) dline[i] = dline[i-1];
        dline[0] = !mute_o;
        if (ack_mode != 0) begin
            nclkmute_i = ack_force;
            ndatmute_i = ack_force;
        end else begin
            nclkmute_i = dline[ack_dly-1];
            ndatmute_i = dline[ack_dly-1];
        end
        if (tick_mode == 0) begin
            fs_tick_i = (tick_ctr == 0);
            tick_ctr  = (tick_ctr == 2) ? 0 : tick_ctr + 1;
        end else begin
            fs_tick_i = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic wait_for(input int st, input int budget, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (int'(state_o) == st) begin
                hit = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        nrst_i = 1'b0; req_i = '0; hold_len_i = 12'd4;
        ack_mode = 0; ack_dly = 10; tick_mode = 0;
        repeat (3) cyc();
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL reset_state: got %0d expected 2", state_o); end
        checks++; if (mute_o !== 1'b1) begin errors++; $display("FAIL reset_mute: got %0b expected 1", mute_o); end
        checks++; if (src_o !== 4'b0000) begin errors++; $display("FAIL reset_src: got %b expected 0000", src_o); end
        checks++; if (tmo_o !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %0b expected 0", tmo_o); end
    endtask

    task automatic test_power_up();
        int ticks = 0;
        bit seen_hold = 1'b0, seen_unm = 1'b0, order_ok = 1'b1, hit = 1'b0;
        nrst_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (state_o == 3'd3) begin
                seen_hold = 1'b1;
                if (fs_tick_i) ticks++;
                if (seen_unm) order_ok = 1'b0;
            end
            if (state_o == 3'd4) begin
                seen_unm = 1'b1;
                if (!seen_hold) order_ok = 1'b0;
            end
            if (state_o == 3'd0) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL powerup_play: got state %0d expected 0", state_o); end
        checks++; if (mute_o !== 1'b0) begin errors++; $display("FAIL powerup_mute: got %0b expected 0", mute_o); end
        checks++; if (ticks != 4) begin errors++; $display("FAIL powerup_ticks: got %0d expected 4", ticks); end
        checks++; if ({seen_hold, seen_unm, order_ok} !== 3'b111) begin errors++; $display("FAIL powerup_order: got %b expected 111", {seen_hold, seen_unm, order_ok}); end
        checks++; if (tmo_o !== 1'b0) begin errors++; $display("FAIL powerup_tmo: got %0b expected 0", tmo_o); end
    endtask

    task automatic test_req_pulse();
        int n = 0, mute_bad = 0;
        bit hit = 1'b0, got_src = 1'b0, seen_unm = 1'b0, play = 1'b0;
        logic [3:0] src_seen = '0;
        req_i = 4'b0100;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 2) req_i = '0;
            if (state_o == 3'd1) begin n = i; hit = 1'b1; break; end
        end
        req_i = '0;
        checks++; if (!hit || n > 3) begin errors++; $display("FAIL pulse_latency: got %0d cycles expected <= 3", n); end
        for (int i = 0; i < 300; i++) begin
            if (state_o == 3'd2 && !got_src) begin src_seen = src_o; got_src = 1'b1; end
            if (state_o == 3'd4) seen_unm = 1'b1;
            if (!seen_unm && mute_o !== 1'b1) mute_bad++;
            if (state_o == 3'd0) begin play = 1'b1; break; end
            cyc();
        end
        checks++; if (src_seen !== 4'b0100) begin errors++; $display("FAIL pulse_src: got %b expected 0100", src_seen); end
        checks++; if (mute_bad != 0) begin errors++; $display("FAIL pulse_mute_held: got %0d early unmute cycles expected 0", mute_bad); end
        checks++; if (!play || mute_o !== 1'b0) begin errors++; $display("FAIL pulse_play: got state %0d mute %0b expected 0/0", state_o, mute_o); end
        checks++; if (src_o !== 4'b0100) begin errors++; $display("FAIL pulse_src_sticky: got %b expected 0100", src_o); end
    endtask

    task automatic test_hold_abort();
        int ticks = 0;
        bit hit, unm = 1'b0, got = 1'b0;
        req_i = 4'b0001;
        wait_for(S_MUTED, 100, hit);
        checks++; if (!hit) begin errors++; $display("FAIL abort_muted: got state %0d expected 2", state_o); end
        req_i = '0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (state_o == 3'd3 && fs_tick_i) ticks++;
            if (ticks == 2) begin got = 1'b1; break; end
        end
        req_i = 4'b0001;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (state_o == 3'd4) unm = 1'b1;
            if (state_o == 3'd2) begin hit = 1'b1; break; end
        end
        checks++; if (!got || !hit || unm) begin errors++; $display("FAIL abort_back_to_muted: got state %0d unmuting_seen %0b expected 2/0", state_o, unm); end
        req_i = '0;
        ticks = 0; hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (state_o == 3'd3 && fs_tick_i) ticks++;
            if (state_o == 3'd4) begin hit = 1'b1; break; end
        end
        checks++; if (!hit || ticks != 4) begin errors++; $display("FAIL abort_full_hold: got %0d ticks expected 4", ticks); end
        wait_for(S_PLAY, 100, hit);
    endtask

    task automatic test_hold_zero();
        int hold_cycles = 0;
        bit hit;
        hold_len_i = 12'd0;
        req_i = 4'b1000;
        wait_for(S_MUTED, 100, hit);
        req_i = '0;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (state_o == 3'd3) hold_cycles++;
            if (state_o == 3'd4) begin hit = 1'b1; break; end
        end
        checks++; if (!hit || hold_cycles != 1) begin errors++; $display("FAIL hold_zero: got %0d hold cycles expected 1", hold_cycles); end
        wait_for(S_PLAY, 100, hit);
        hold_len_i = 12'd4;
    endtask

    task automatic test_timeout();
        int n = 0;
        bit hit;
        ack_mode = 1; ack_force = 1'b1;
        req_i = 4'b0010;
        wait_for(S_MUTING, 10, hit);
        for (int i = 0; i < 40; i++) begin
            if (state_o == 3'd1) n++;
            else break;
            cyc();
        end
        checks++; if (!hit || n != 15 || state_o !== 3'd2) begin errors++; $display("FAIL timeout_cycles: got %0d cycles state %0d expected 15/2", n, state_o); end
        checks++; if (tmo_o !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %0b expected 1", tmo_o); end
        req_i = '0;
        wait_for(S_PLAY, 100, hit);
        checks++; if (!hit || tmo_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b expected 1", tmo_o); end
        req_i = 4'b0001;
        wait_for(S_MUTING, 10, hit);
        checks++; if (!hit || tmo_o !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %0b expected 0", tmo_o); end
        ack_mode = 0;
        req_i = '0;
        wait_for(S_PLAY, 300, hit);
    endtask

    task automatic test_abort_priority();
        bit hit;
        ack_mode = 0;
        req_i = 4'b1000;
        wait_for(S_MUTED, 100, hit);
        req_i = '0;
        wait_for(S_UNMUTING, 200, hit);
        // Acks and request launched on the same edge reach the FSM together.
        nclkmute_i = 1'b1; ndatmute_i = 1'b1;
        ack_mode = 1; ack_force = 1'b1;
        req_i = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (state_o != 3'd4) break;
        end
        checks++; if (!hit || state_o !== 3'd1) begin errors++; $display("FAIL abort_priority: got state %0d expected 1", state_o); end
        ack_mode = 0;
        req_i = '0;
        wait_for(S_PLAY, 300, hit);
    endtask

    task automatic test_async_reset();
        bit hit;
        req_i = 4'b0001;
        wait_for(S_MUTED, 100, hit);
        req_i = '0;
        wait_for(S_UNMUTING, 200, hit);
        #2;
        nrst_i = 1'b0;
        #1;
        checks++; if (!hit || mute_o !== 1'b1) begin errors++; $display("FAIL async_reset_mute: got %0b expected 1", mute_o); end
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL async_reset_state: got %0d expected 2", state_o); end
        checks++; if (src_o !== 4'b0000 || tmo_o !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got src %b tmo %0b expected 0000/0", src_o, tmo_o); end
        cyc();
        cyc();
        nrst_i = 1'b1;
        wait_for(S_PLAY, 300, hit);
        checks++; if (!hit || mute_o !== 1'b0) begin errors++; $display("FAIL async_reset_recover: got state %0d mute %0b expected 0/0", state_o, mute_o); end
    endtask

    task automatic test_random();
        int r;
        bit exp_mute;
        tick_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            exp_mute = (m_state == S_MUTING) || (m_state == S_MUTED) || (m_state == S_HOLD);
            checks++; if (int'(state_o) != m_state) begin errors++; $display("FAIL rand_state cycle %0d: got %0d expected %0d", c, state_o, m_state); end
            checks++; if (mute_o !== exp_mute) begin errors++; $display("FAIL rand_mute cycle %0d: got %0b expected %0b", c, mute_o, exp_mute); end
            checks++; if (src_o !== m_src) begin errors++; $display("FAIL rand_src cycle %0d: got %b expected %b", c, src_o, m_src); end
            checks++; if (tmo_o !== m_tmo) begin errors++; $display("FAIL rand_tmo cycle %0d: got %0b expected %0b", c, tmo_o, m_tmo); end

            if (!nrst_i) nrst_i = 1'b1;
            else if ($urandom_range(0, 599) == 0) nrst_i = 1'b0;
            r = int'($urandom_range(0, 29));
            if (r == 0) req_i = req_i | 4'(1 << $urandom_range(0, 3));
            else if (r == 1) req_i = req_i ^ 4'(1 << $urandom_range(0, 3));
            else if (r < 5) req_i = '0;
            if ($urandom_range(0, 99) == 0) hold_len_i = 12'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) ack_dly = int'($urandom_range(1, 14));
            if ($urandom_range(0, 299) == 0) begin
                ack_mode  = 1;
                ack_force = 1'($urandom_range(0, 1));
            end else if (ack_mode != 0 && $urandom_range(0, 39) == 0) begin
                ack_mode = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_req_pulse();
        test_hold_abort();
        test_hold_zero();
        test_timeout();
        test_abort_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
